// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall vectors, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam int CTRL_WIDTH = 6;
  localparam int EXC_TYPE_W = 5;

  localparam logic [EXC_TYPE_W-1:0] EXC_SYSCALL = 5'h08;
  localparam logic [EXC_TYPE_W-1:0] EXC_ERET    = 5'h0e;

  // Bit k set means stage k holds; the lowest clear bit above a set bit gets a bubble.
  localparam logic [CTRL_WIDTH-1:0] STALL_NONE = 6'b000000;
  localparam logic [CTRL_WIDTH-1:0] STALL_IF   = 6'b000011;
  localparam logic [CTRL_WIDTH-1:0] STALL_ID   = 6'b000111;
  localparam logic [CTRL_WIDTH-1:0] STALL_EX   = 6'b001111;
  localparam logic [CTRL_WIDTH-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  function automatic logic [CTRL_WIDTH-1:0] stall_encode(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Bus-wait watchdog: counts consecutive busy cycles and pulses timeout once per TIMEOUT_CYCLES.
module stall_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic clr,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else if (clr || !busy) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else if (run_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      // This cycle is the Nth consecutive busy one: pulse and start a fresh window.
      run_cnt <= '0;
      timeout <= 1'b1;
    end else begin
      run_cnt <= run_cnt + 1'b1;
      timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception/ERET flush with PC redirect, bus watchdog, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  excp_valid,
  input  logic [EXC_TYPE_W-1:0] excp_type,
  input  logic [31:0]           epc_in,
  input  logic                  perf_clr,
  output logic [CTRL_WIDTH-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  state_t                state;
  logic [EXC_TYPE_W-1:0] exc_type_q;
  logic [31:0]           epc_q;

  function automatic logic [31:0] redirect(input logic [EXC_TYPE_W-1:0] t, input logic [31:0] epc);
    return (t == EXC_ERET) ? epc : EXC_VECTOR;
  endfunction

  // Acceptance cycles force MEM/WB into a bubble so the faulting instruction never commits.
  always_comb begin
    stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    case (state)
      ST_RUN:      if (excp_valid) stall = STALL_MEM;
      ST_WAIT_MEM: stall = STALL_MEM;
      ST_FLUSH:    stall = STALL_NONE;
      default:     stall = STALL_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush      <= 1'b0;
      new_pc     <= '0;
      exc_type_q <= '0;
      epc_q      <= '0;
    end else begin
      flush  <= 1'b0;
      new_pc <= '0;
      case (state)
        ST_RUN: begin
          if (excp_valid) begin
            exc_type_q <= excp_type;
            epc_q      <= epc_in;
            if (!stallreq_mem) begin
              state  <= ST_FLUSH;
              flush  <= 1'b1;
              new_pc <= redirect(excp_type, epc_in);
            end else begin
              state <= ST_WAIT_MEM;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (!stallreq_mem) begin
            state  <= ST_FLUSH;
            flush  <= 1'b1;
            new_pc <= redirect(exc_type_q, epc_q);
          end
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (stallreq_if | stallreq_mem),
    .clr    (state == ST_FLUSH),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr)
      stall_cycles <= '0;
    else if (stall[0] && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int T_OUT = 8;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_if, req_id, req_ex, req_mem;
  logic                  excp_valid;
  logic [EXC_TYPE_W-1:0] excp_type;
  logic [31:0]           epc_in;
  logic                  perf_clr;
  logic [CTRL_WIDTH-1:0] stall;
  logic                  flush;
  logic [31:0]           new_pc;
  logic                  timeout;
  logic [CW-1:0]         stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  // Model state: flush output, pending deferred exception, watchdog run length, perf count.
  bit          m_flush;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [4:0]  m_type;
  logic [31:0] m_epc;
  int          m_run;
  bit          m_to;
  int          m_cnt;
  int          pulses;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .TIMEOUT_CYCLES(T_OUT),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stallreq_if (req_if),
    .stallreq_id (req_id),
    .stallreq_ex (req_ex),
    .stallreq_mem(req_mem),
    .excp_valid  (excp_valid),
    .excp_type   (excp_type),
    .epc_in      (epc_in),
    .perf_clr    (perf_clr),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .timeout     (timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int level_mask(input int level);
    return (level == 0) ? 0 : ((1 << level) - 1);
  endfunction

  task automatic set_in(input bit i_if, input bit i_id, input bit i_ex, input bit i_mem,
                        input bit ev, input logic [4:0] et, input logic [31:0] epc, input bit pc);
    req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
    excp_valid = ev; excp_type = et; epc_in = epc; perf_clr = pc;
  endtask

  // One clock: check outputs at negedge, advance the model across the posedge.
  task automatic step();
    int          es, lvl;
    bit          acc, n_pend, n_to;
    logic [31:0] n_pc, tgt;
    logic [4:0]  n_type;
    logic [31:0] n_epc;
    int          n_run, n_cnt;
    @(negedge clk);
    lvl = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
    if (m_flush)                   es = 0;
    else if (m_pend || excp_valid) es = 31;
    else                           es = level_mask(lvl);
    chk("stall", 64'(stall), 64'(es));
    chk("flush", 64'(flush), 64'(m_flush));
    if (m_flush) chk("new_pc", 64'(new_pc), 64'(m_pc));
    chk("timeout", 64'(timeout), 64'(m_to));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    if (timeout === 1'b1) pulses++;

    n_type = m_type; n_epc = m_epc;
    if (!m_flush && !m_pend && excp_valid) begin
      n_type = excp_type; n_epc = epc_in;
    end
    acc    = !m_flush && (m_pend || excp_valid) && !req_mem;
    n_pend = !m_flush && (m_pend || excp_valid) && req_mem;
    tgt    = (n_type == EXC_ERET) ? n_epc : 32'h20;
    n_pc   = acc ? tgt : 32'h0;
    n_to   = 0;
    n_run  = 0;
    if (!m_flush && (req_if || req_mem)) begin
      n_run = m_run + 1;
      if (n_run == T_OUT) begin n_to = 1; n_run = 0; end
    end
    n_cnt = m_cnt;
    if (perf_clr) n_cnt = 0;
    else if ((es & 1) != 0 && m_cnt < 15) n_cnt = m_cnt + 1;

    @(posedge clk);
    if (!rst_n) begin
      m_flush = 0; m_pc = 0; m_pend = 0; m_type = 0; m_epc = 0;
      m_run = 0; m_to = 0; m_cnt = 0;
    end else begin
      m_flush = acc; m_pc = n_pc; m_pend = n_pend; m_type = n_type; m_epc = n_epc;
      m_run = n_run; m_to = n_to; m_cnt = n_cnt;
    end
    #1;
  endtask

  initial begin
    m_flush = 0; m_pc = 0; m_pend = 0; m_type = 0; m_epc = 0;
    m_run = 0; m_to = 0; m_cnt = 0; pulses = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_new_pc", 64'(new_pc), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));

    // Stall priority merge.
    set_in(0, 1, 1, 0, 0, 0, 0, 0); step();
    set_in(0, 1, 1, 1, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Syscall accepted immediately; flush cycle overrides a load-use stall.
    set_in(0, 0, 0, 0, 1, EXC_SYSCALL, 32'h1234_5678, 0); step();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_flush", 64'(flush), 64'(1));
    chk("t2_pc", 64'(new_pc), 64'(32'h20));
    step();
    chk("t2_flush_drop", 64'(flush), 64'(0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // ERET deferred behind a 3-cycle data bus wait.
    set_in(0, 0, 0, 1, 1, EXC_ERET, 32'h0040_1000, 0); step();
    set_in(0, 1, 0, 1, 0, 0, 0, 0); step(); step();
    set_in(0, 0, 0, 0, 1, EXC_SYSCALL, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_flush", 64'(flush), 64'(1));
    chk("t3_pc", 64'(new_pc), 64'(32'h0040_1000));
    step(); step();

    // Watchdog: 20 busy cycles, then again with an idle gap at cycle 5.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin set_in(0, 0, 0, 1, 0, 0, 0, 0); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t4_pulses", 64'(pulses), 64'(2));
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin set_in(0, 0, 0, i != 5, 0, 0, 0, 0); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t4_gap_pulses", 64'(pulses), 64'(1));

    // Reset while a deferred exception waits on memory.
    set_in(0, 0, 0, 1, 1, EXC_SYSCALL, 0, 0); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("t5_no_flush", 64'(flush), 64'(0));

    // Counter saturation and clear.
    set_in(0, 0, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 20; i++) begin set_in(0, 1, 0, 0, 0, 0, 0, 0); step(); end
    chk("t6_sat", 64'(stall_cycles), 64'(4'hF));
    set_in(0, 1, 0, 0, 0, 0, 0, 1); step();
    chk("t6_clr", 64'(stall_cycles), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 1) ? EXC_ERET : 5'($urandom_range(0, 31)),
             $urandom, $urandom_range(0, 40) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
